// File: rtl/alu_pkg.sv
// Shared ALU control encoding and RV32I OP/OP-IMM decode constants for the issue stage.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_ctrl_e f3_to_ctrl(input logic [2:0] f3, input logic alt);
        alu_ctrl_e c;
        unique case (f3)
            F3_ADD:  c = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  c = ALU_SLL;
            F3_SLT:  c = ALU_SLT;
            F3_SLTU: c = ALU_SLTU;
            F3_XOR:  c = ALU_XOR;
            F3_SR:   c = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, ALU operand/result bus and writeback signals of the issue stage.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            zero_flag;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_zero;
    logic [15:0]     illegal_cnt;

    modport master (
        output in_valid, in_instr, alu_result, zero_flag,
        input  in_ready, operand_a, operand_b, alu_ctrl,
        input  wb_valid, wb_rd, wb_data, wb_zero, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, alu_result, zero_flag,
        output in_ready, operand_a, operand_b, alu_ctrl,
        output wb_valid, wb_rd, wb_data, wb_zero, illegal_cnt
    );
endinterface

// File: rtl/alu_regfile.sv
// NREG x XLEN register file: two asynchronous read ports, one write port, x0 hardwired to zero.
module alu_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // No write-through: same-cycle producers are covered by the stage's forwarding path
    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM issue stage feeding a one-cycle registered ALU, with one-cycle
// stall on S1 dependencies, forwarding from the ALU output and writeback.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 32
) (
    input logic clk,
    input logic rst_n,
    alu_issue_stage_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];

    logic      is_op, is_op_imm, legal;
    alu_ctrl_e dec_ctrl;

    always_comb begin
        is_op     = (opcode == OPC_OP);
        is_op_imm = (opcode == OPC_OP_IMM);
        legal     = 1'b0;
        dec_ctrl  = ALU_ADD;
        if (is_op) begin
            legal    = (funct7 == F7_BASE) ||
                       (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
            dec_ctrl = f3_to_ctrl(funct3, funct7[5]);
        end else if (is_op_imm) begin
            unique case (funct3)
                F3_SLL:  legal = (funct7 == F7_BASE);
                F3_SR:   legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                default: legal = 1'b1;
            endcase
            dec_ctrl = f3_to_ctrl(funct3, (funct3 == F3_SR) && funct7[5]);
        end
    end

    logic            s1_valid, s2_valid;
    logic [4:0]      s1_rd, s2_rd;
    logic [XLEN-1:0] op_a_q, op_b_q;
    alu_ctrl_e       ctrl_q;
    logic [15:0]     illegal_q;

    logic stall, accept, issue;

    // rs2 only counts as a source for register-register ops
    assign stall  = s1_valid && (s1_rd != '0) &&
                    (((is_op || is_op_imm) && rs1 == s1_rd) || (is_op && rs2 == s1_rd));
    assign accept = bus.in_valid && !stall;
    assign issue  = accept && legal;

    logic [XLEN-1:0] rf_a, rf_b, src_a, src_b, imm_i, shamt, op_b_next;
    logic            wb_en;

    assign wb_en = s2_valid && (s2_rd != '0);

    alu_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (s2_rd[AW-1:0]),
        .wdata   (bus.alu_result),
        .raddr_a (rs1[AW-1:0]),
        .rdata_a (rf_a),
        .raddr_b (rs2[AW-1:0]),
        .rdata_b (rf_b)
    );

    assign src_a = (wb_en && s2_rd == rs1) ? bus.alu_result : rf_a;
    assign src_b = (wb_en && s2_rd == rs2) ? bus.alu_result : rf_b;

    assign imm_i = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign shamt = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};

    always_comb begin
        op_b_next = imm_i;
        if (is_op) begin
            op_b_next = src_b;
        end else if (funct3 == F3_SLL || funct3 == F3_SR) begin
            op_b_next = shamt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_rd     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            ctrl_q    <= ALU_ADD;
            s2_valid  <= 1'b0;
            s2_rd     <= '0;
            illegal_q <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_rd  <= rd;
                op_a_q <= src_a;
                op_b_q <= op_b_next;
                ctrl_q <= dec_ctrl;
            end
            s2_valid <= s1_valid;
            s2_rd    <= s1_rd;
            if (accept && !legal && illegal_q != '1) begin
                illegal_q <= illegal_q + 16'd1;
            end
        end
    end

    assign bus.in_ready    = !stall;
    assign bus.operand_a   = op_a_q;
    assign bus.operand_b   = op_b_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.wb_valid    = wb_en;
    assign bus.wb_rd       = s2_rd;
    assign bus.wb_data     = bus.alu_result;
    assign bus.wb_zero     = wb_en && bus.zero_flag;
    assign bus.illegal_cnt = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with a behavioural registered ALU attached.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.XLEN(32)) bus();

    alu_issue_stage #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            default:  return 32'h0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_result <= '0;
            bus.zero_flag  <= 1'b0;
        end else begin
            bus.alu_result <= alu_f(bus.operand_a, bus.operand_b, bus.alu_ctrl);
            bus.zero_flag  <= (alu_f(bus.operand_a, bus.operand_b, bus.alu_ctrl) == 32'h0);
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
    } wb_t;
    wb_t wbq[$];

    always @(negedge clk) begin
        if (bus.wb_valid) wbq.push_back('{bus.wb_rd, bus.wb_data, bus.wb_zero});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input int r2, input int r1,
                                          input logic [2:0] f3, input int d);
        return {f7, 5'(r2), 5'(r1), f3, 5'(d), OPC_OP};
    endfunction

    function automatic logic [31:0] itype(input int imm, input int r1, input logic [2:0] f3, input int d);
        return {12'(imm), 5'(r1), f3, 5'(d), OPC_OP_IMM};
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge
    task automatic send(input logic [31:0] ins);
        logic accepted;
        accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        for (int k = 0; k < 8 && !accepted; k++) begin
            #1;
            if (bus.in_ready) accepted = 1'b1;
            else stall_cnt++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept instr=%h", ins);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        #1;
        chk({tag, "_in_ready"},    32'(bus.in_ready),    32'h1);
        chk({tag, "_operand_a"},   bus.operand_a,        32'h0);
        chk({tag, "_operand_b"},   bus.operand_b,        32'h0);
        chk({tag, "_alu_ctrl"},    32'(bus.alu_ctrl),    32'h0);
        chk({tag, "_wb_valid"},    32'(bus.wb_valid),    32'h0);
        chk({tag, "_wb_rd"},       32'(bus.wb_rd),       32'h0);
        chk({tag, "_wb_zero"},     32'(bus.wb_zero),     32'h0);
        chk({tag, "_illegal_cnt"}, 32'(bus.illegal_cnt), 32'h0);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        check_reset(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic exp_wb(input string name, input int idx, input int rd, input logic [31:0] data);
        if (idx < wbq.size()) begin
            chk({name, "_rd"},   32'(wbq[idx].rd),   32'(rd));
            chk({name, "_data"}, wbq[idx].data,      data);
            chk({name, "_zero"}, 32'(wbq[idx].zero), 32'(data == 32'h0));
        end else begin
            checks++;
            failures++;
            $display("FAIL %s_missing actual=%0d_writebacks required=more_than_%0d", name, wbq.size(), idx);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        wb;
        int          rd;
        logic [31:0] data;
    } vec_t;

    initial begin
        vec_t vecs[$];

        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Each vector drains fully, so operands come from the register file
        vecs.push_back('{"addi_x1",   itype(10, 0, F3_ADD, 1),            1'b1, 1,  32'd10});
        vecs.push_back('{"addi_x2",   itype(20, 0, F3_ADD, 2),            1'b1, 2,  32'd20});
        vecs.push_back('{"add_x3",    rtype(F7_BASE, 2, 1, F3_ADD, 3),    1'b1, 3,  32'd30});
        vecs.push_back('{"sub_x4",    rtype(F7_ALT, 2, 1, F3_ADD, 4),     1'b1, 4,  32'hFFFF_FFF6});
        vecs.push_back('{"slt_x5",    rtype(F7_BASE, 1, 4, F3_SLT, 5),    1'b1, 5,  32'd1});
        vecs.push_back('{"sltu_x6",   rtype(F7_BASE, 1, 4, F3_SLTU, 6),   1'b1, 6,  32'd0});
        vecs.push_back('{"xori_x7",   itype(-1, 1, F3_XOR, 7),            1'b1, 7,  32'hFFFF_FFF5});
        vecs.push_back('{"ori_x8",    itype('h7F0, 1, F3_OR, 8),          1'b1, 8,  32'h0000_07FA});
        vecs.push_back('{"andi_x9",   itype('hF, 3, F3_AND, 9),           1'b1, 9,  32'h0000_000E});
        vecs.push_back('{"slti_x10",  itype(-9, 4, F3_SLT, 10),           1'b1, 10, 32'd1});
        vecs.push_back('{"sltiu_x11", itype(-1, 1, F3_SLTU, 11),          1'b1, 11, 32'd1});
        vecs.push_back('{"slli_x12",  itype(28, 1, F3_SLL, 12),           1'b1, 12, 32'hA000_0000});
        vecs.push_back('{"srai_x13",  itype('h404, 12, F3_SR, 13),        1'b1, 13, 32'hFA00_0000});
        vecs.push_back('{"srli_x14",  itype(4, 12, F3_SR, 14),            1'b1, 14, 32'h0A00_0000});
        vecs.push_back('{"srl_x15",   rtype(F7_BASE, 1, 12, F3_SR, 15),   1'b1, 15, 32'h0028_0000});
        vecs.push_back('{"sra_x16",   rtype(F7_ALT, 1, 12, F3_SR, 16),    1'b1, 16, 32'hFFE8_0000});
        vecs.push_back('{"sll_x17",   rtype(F7_BASE, 2, 1, F3_SLL, 17),   1'b1, 17, 32'h00A0_0000});
        vecs.push_back('{"and_x18",   rtype(F7_BASE, 2, 3, F3_AND, 18),   1'b1, 18, 32'd20});
        vecs.push_back('{"or_x19",    rtype(F7_BASE, 2, 1, F3_OR, 19),    1'b1, 19, 32'd30});
        vecs.push_back('{"xor_x20",   rtype(F7_BASE, 2, 3, F3_XOR, 20),   1'b1, 20, 32'd10});
        vecs.push_back('{"addi_x0",   itype(5, 0, F3_ADD, 0),             1'b0, 0,  32'd0});
        vecs.push_back('{"add_x21_x0", rtype(F7_BASE, 0, 0, F3_ADD, 21),  1'b1, 21, 32'd0});
        vecs.push_back('{"lw_drop",   {12'd0, 5'd1, 3'b010, 5'd22, 7'b0000011}, 1'b0, 0, 32'd0});
        vecs.push_back('{"mul_drop",  rtype(7'b0000001, 2, 1, F3_ADD, 23), 1'b0, 0, 32'd0});
        vecs.push_back('{"slli_bad_f7", itype('h41F, 1, F3_SLL, 27),      1'b0, 0, 32'd0});
        vecs.push_back('{"addi_min",  itype(-2048, 0, F3_ADD, 24),        1'b1, 24, 32'hFFFF_F800});
        vecs.push_back('{"addi_max",  itype(2047, 0, F3_ADD, 25),         1'b1, 25, 32'h0000_07FF});
        vecs.push_back('{"add_wrap",  rtype(F7_BASE, 12, 12, F3_ADD, 26), 1'b1, 26, 32'h4000_0000});

        foreach (vecs[i]) begin
            wbq.delete();
            send(vecs[i].instr);
            drain(4);
            chk({vecs[i].name, "_wbcount"}, 32'(wbq.size()), 32'(vecs[i].wb));
            if (vecs[i].wb) exp_wb(vecs[i].name, 0, vecs[i].rd, vecs[i].data);
        end
        chk("table_illegal_cnt", 32'(bus.illegal_cnt), 32'd3);

        // Dependent pair: one stall, second source forwarded from ALU output
        reset_pulse("seqA_rst");
        wbq.delete(); stall_cnt = 0;
        send(itype(10, 0, F3_ADD, 1));
        send(itype(20, 0, F3_ADD, 2));
        send(rtype(F7_BASE, 2, 1, F3_ADD, 3));
        drain(4);
        chk("seqA_stalls", 32'(stall_cnt), 32'd1);
        chk("seqA_wbcount", 32'(wbq.size()), 32'd3);
        exp_wb("seqA_x1", 0, 1, 32'd10);
        exp_wb("seqA_x2", 1, 2, 32'd20);
        exp_wb("seqA_x3", 2, 3, 32'd30);

        // NOP in between: no stall, SUB sources forwarded
        wbq.delete(); stall_cnt = 0;
        send(itype(30, 0, F3_ADD, 1));
        send(itype(0, 0, F3_ADD, 0));
        send(rtype(F7_ALT, 1, 1, F3_ADD, 2));
        drain(4);
        chk("seqB_stalls", 32'(stall_cnt), 32'd0);
        chk("seqB_wbcount", 32'(wbq.size()), 32'd2);
        exp_wb("seqB_x1", 0, 1, 32'd30);
        exp_wb("seqB_x2", 1, 2, 32'd0);

        wbq.delete(); stall_cnt = 0;
        send(itype(-1, 0, F3_ADD, 1));
        send(itype('h404, 1, F3_SR, 2));
        send(itype(28, 1, F3_SR, 3));
        drain(4);
        chk("seqC_stalls", 32'(stall_cnt), 32'd1);
        chk("seqC_wbcount", 32'(wbq.size()), 32'd3);
        exp_wb("seqC_x1", 0, 1, 32'hFFFF_FFFF);
        exp_wb("seqC_x2", 1, 2, 32'hFFFF_FFFF);
        exp_wb("seqC_x3", 2, 3, 32'h0000_000F);

        wbq.delete(); stall_cnt = 0;
        send(itype(1, 0, F3_ADD, 1));
        send(itype(5, 1, F3_SLL, 2));
        send(rtype(F7_BASE, 2, 0, F3_SLTU, 3));
        send(itype(5, 0, F3_ADD, 0));
        send(rtype(F7_BASE, 0, 0, F3_ADD, 4));
        drain(4);
        chk("seqD_stalls", 32'(stall_cnt), 32'd2);
        chk("seqD_wbcount", 32'(wbq.size()), 32'd4);
        exp_wb("seqD_x1", 0, 1, 32'd1);
        exp_wb("seqD_x2", 1, 2, 32'd32);
        exp_wb("seqD_x3", 2, 3, 32'd1);
        exp_wb("seqD_x4_x0", 3, 4, 32'd0);

        // Back-to-back illegal instructions after a fresh reset
        reset_pulse("seqE_rst");
        wbq.delete();
        send({12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011});
        send(rtype(7'b0000001, 2, 1, F3_ADD, 6));
        drain(4);
        chk("seqE_wbcount", 32'(wbq.size()), 32'd0);
        chk("seqE_illegal_cnt", 32'(bus.illegal_cnt), 32'd2);

        // Reset lands while ADD x5 sits in S1
        send(itype(7, 0, F3_ADD, 1));
        send(itype(9, 0, F3_ADD, 2));
        drain(4);
        wbq.delete();
        send(rtype(F7_BASE, 2, 1, F3_ADD, 5));
        rst_n = 1'b0;
        check_reset("seqF_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drain(4);
        chk("seqF_no_wb", 32'(wbq.size()), 32'd0);
        send(rtype(F7_BASE, 0, 5, F3_ADD, 6));
        drain(4);
        send(rtype(F7_BASE, 2, 1, F3_ADD, 7));
        drain(4);
        chk("seqF_wbcount", 32'(wbq.size()), 32'd2);
        exp_wb("seqF_x5_cleared", 0, 6, 32'd0);
        exp_wb("seqF_x1x2_cleared", 1, 7, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue stage directly upstream of the registered ALU (`alu`, one-cycle result latency). Accepts RISC-V RV32I OP/OP-IMM instruction words over a valid/ready handshake, reads operands from an internal register file, and drives `operand_a`/`operand_b`/`alu_ctrl` to the ALU. It writes `alu_result` back to the destination register one cycle later. Resolves the single read-after-write hazard created by the ALU's output register with one stall cycle plus forwarding.

## Interface
- `XLEN`, 32: datapath width; must match the ALU.
- `NREG`, 32: architectural registers; index width is clog2(NREG); x0 reads as 0.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert and active-low; synchronous release to `clk`.
- `in_valid`  in  1  instruction word valid.
- `in_instr`  in  32  RV32I instruction.
- `in_ready`  out  1  stage can accept; combinational on `in_instr` and the S1 state.
- `operand_a`  out  XLEN  registered to ALU.
- `operand_b`  out  XLEN  registered to ALU.
- `alu_ctrl`  out  4  registered to ALU.
- `alu_result`  in  XLEN  registered ALU output.
- `zero_flag`  in  1  ALU zero flag; passed to `wb_zero`.
- `wb_valid`  out  1  writeback occurring this cycle.
- `wb_rd`  out  5  writeback register index.
- `wb_data`  out  XLEN  writeback data (= `alu_result`).
- `wb_zero`  out  1  `zero_flag` qualified by `wb_valid`.
- `illegal_cnt`  out  16  saturating count of dropped non-ALU instructions.

## Operation
- alu_ctrl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- OP (0110011): funct3/funct7 select ADD/SUB (funct7 0100000), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. `operand_b` = rs2 value.
- OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI use the 12-bit immediate, sign-extended to XLEN. SLLI/SRLI/SRAI use `operand_b` = zero-extended imm[4:0]. SRAI is selected by imm[11:5] = 0100000.
- Any other opcode, or an illegal funct7 (for example OP with funct7 0000001): accepted, dropped, and no writeback. `illegal_cnt` increments and saturates at 0xFFFF.
- Pipeline: S1 is the issue registers (valid, rd, operands, ctrl). S2 is the ALU result register plus an internal valid/rd shadow.
- rd = x0: the instruction executes, but `wb_valid` stays 0.
- Stall: `in_ready`=0 when S1 is valid, S1.rd≠0, and the incoming instruction reads rs1 or rs2 = S1.rd. rs2 counts as read only for OP.
- Forward: if S2 is valid with S2.rd≠0 matching a source, use `alu_result` instead of the register file.
- Reads see writes of the same cycle through the forwarding path, never through register-file write-through.
- Dropped instructions and stall bubbles load S1.valid=0; the ALU outputs hold their last values.

## Timing
- Accept at edge E0 → operands and ctrl valid after E0 → ALU latches at E1 → `wb_*` valid between E1 and E2 → register file written at E2.
- Throughput: one instruction per cycle when independent. Back-to-back dependent pairs cost one stall cycle.
- Reset (any time, including mid-stream): S1/S2 valid=0, `in_ready`=1, `operand_a`=`operand_b`=0, `alu_ctrl`=0000, `wb_valid`=0, `wb_rd`=0, `wb_zero`=0, `illegal_cnt`=0, all registers 0. In-flight instructions are discarded with no writeback.
- `in_valid` low: S1.valid=0 next cycle; no other state changes.
- Arithmetic is modulo 2^XLEN; immediate sign-extension is from bit 11.

## Structure
- `alu_pkg`: alu_ctrl enum, opcode/funct3/funct7 constants, XLEN default.
- Sub-module `alu_regfile`: NREG×XLEN, two async read ports, one write port, async reset clear, x0 hardwired to 0.
- Decode, hazard detection, forwarding and S1/S2 registers live in the top block.

## Test plan
- Reset, then ADDI x1,x0,10; ADDI x2,x0,20; ADD x3,x1,x2 → writebacks x1=10, x2=20, x3=30. One stall before the ADD, with `in_ready`=0 for one cycle.
- ADDI x1,x0,30; NOP; SUB x2,x1,x1 → forward from `alu_result`, x2=0, `wb_zero`=1, no stall.
- ADDI x1,x0,-1; SRAI x2,x1,4; SRLI x3,x1,28 → x1=0xFFFFFFFF, x2=0xFFFFFFFF, x3=0xF.
- ADDI x1,x0,1; SLLI x2,x1,5; SLTU x3,x0,x2 → x2=32, x3=1. Then ADDI x0,x0,5 → `wb_valid`=0 and x0 still 0.
- Feed LW (0000011) then MUL (OP, funct7 0000001) → no writebacks, `illegal_cnt`=2.
- Assert `rst_n`=0 during the cycle after accepting ADD x5,... → `wb_valid` never asserts for it, x5=0, all outputs at reset values.
